// File: rtl/prio_decoder_buf.sv
// prio_decoder_buf: buffered binary-to-one-hot decoder.
// Codes enter over a valid/ready handshake into a 2-entry FIFO. The head entry is
// presented as a one-hot word on a second valid/ready interface.
// Optional feature: define PRIO_DEC_CNT_EN to add a 16-bit wrapping pop counter
// on output port dec_count.
module prio_decoder_buf #(
    parameter int CODE_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CODE_W-1:0]    code,
    input  logic                 code_valid,
    output logic                 code_ready,
    output logic [2**CODE_W-1:0] onehot,
    output logic                 out_valid,
`ifdef PRIO_DEC_CNT_EN
    output logic [15:0]          dec_count,
`endif
    input  logic                 out_ready
);

    localparam int OUT_W = 2**CODE_W;

    logic [CODE_W-1:0] fifo_q [2];
    logic [CODE_W-1:0] fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push;
    logic              pop;

    // Handshake flags depend only on the occupancy register, so there is no
    // combinational path from out_ready back to code_ready.
    always_comb begin
        code_ready = (count_q != 2'd2);
        out_valid  = (count_q != 2'd0);
        push       = code_valid & code_ready;
        pop        = out_valid & out_ready;
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = code;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all buffered codes at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Decode the head entry; all zeros whenever nothing is buffered.
    always_comb begin
        onehot = '0;
        if (out_valid) begin
            onehot = {{(OUT_W-1){1'b0}}, 1'b1} << fifo_q[rd_ptr_q];
        end
    end

`ifdef PRIO_DEC_CNT_EN
    logic [15:0] dec_count_q, dec_count_d;

    // Pop counter next-state; 16-bit rollover is intentional.
    always_comb begin
        dec_count_d = dec_count_q;
        if (pop) begin
            dec_count_d = dec_count_q + 16'd1;
        end
    end

    // Pop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_count_q <= 16'd0;
        end else begin
            dec_count_q <= dec_count_d;
        end
    end

    assign dec_count = dec_count_q;
`endif

endmodule

// File: tb/tb_prio_decoder_buf.sv
// Directed testbench for prio_decoder_buf (CODE_W=3, OUT_W=8).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_prio_decoder_buf;

    logic       clk;
    logic       rst_n;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] onehot;
    logic       out_valid;
    logic       out_ready;
`ifdef PRIO_DEC_CNT_EN
    logic [15:0] dec_count;
`endif

    int checks;
    int failures;

    prio_decoder_buf #(.CODE_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .onehot     (onehot),
        .out_valid  (out_valid),
`ifdef PRIO_DEC_CNT_EN
        .dec_count  (dec_count),
`endif
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check both outputs of the decode interface in one call.
    task automatic chk_out(input string tag, input logic v, input logic [7:0] oh);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_onehot"}, 32'(onehot), 32'(oh));
    endtask

    logic [7:0] one;

    initial begin
        checks     = 0;
        failures   = 0;
        one        = 8'h01;
        rst_n      = 1'b0;
        code       = 3'd0;
        code_valid = 1'b0;
        out_ready  = 1'b0;

        // 1. Reset
        #3;
        chk_out("rst", 1'b0, 8'h00);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_code_ready", 32'(code_ready), 32'd1);
        chk_out("rst_rel", 1'b0, 8'h00);
`ifdef PRIO_DEC_CNT_EN
        chk("rst_dec_count", 32'(dec_count), 32'd0);
`endif

        // Pop while empty has no effect
        out_ready = 1'b1;
        cyc();
        chk_out("empty_pop", 1'b0, 8'h00);

        // 2. Single decode of code 5
        code = 3'd5; code_valid = 1'b1;
        cyc();
        code_valid = 1'b0; code = 3'd2;
        chk_out("single", 1'b1, 8'h20);
        cyc();
        chk_out("single_drain", 1'b0, 8'h00);

        // 3. Sweep 0..7 back-to-back
        for (int i = 0; i < 8; i++) begin
            code = 3'(i); code_valid = 1'b1;
            cyc();
            chk_out($sformatf("sweep%0d", i), 1'b1, one << i);
            chk($sformatf("sweep%0d_ready", i), 32'(code_ready), 32'd1);
        end
        code_valid = 1'b0;
        cyc();
        chk_out("sweep_drain", 1'b0, 8'h00);

        // 4. Backpressure
        out_ready = 1'b0;
        code = 3'd1; code_valid = 1'b1;
        cyc();
        chk("bp1_ready", 32'(code_ready), 32'd1);
        chk_out("bp1", 1'b1, 8'h02);
        code = 3'd6;
        cyc();
        chk("bp2_ready", 32'(code_ready), 32'd0);
        chk_out("bp2", 1'b1, 8'h02);
        code = 3'd7;                    // offered while full: must be ignored
        cyc();
        chk("bp_full_ready", 32'(code_ready), 32'd0);
        chk_out("bp_hold", 1'b1, 8'h02);
        code = 3'd3; out_ready = 1'b1;  // pop only; no slot yet at this edge
        cyc();
        chk_out("bp_pop1", 1'b1, 8'h40);
        chk("bp_freed_ready", 32'(code_ready), 32'd1);
        cyc();                          // pop 6, push 3
        code_valid = 1'b0;
        chk_out("bp_third", 1'b1, 8'h08);
        cyc();
        chk_out("bp_drain", 1'b0, 8'h00);

        // 5. Simultaneous push/pop at count 1
        out_ready = 1'b0;
        code = 3'd2; code_valid = 1'b1;
        cyc();
        chk_out("pp_load", 1'b1, 8'h04);
        out_ready = 1'b1; code = 3'd4;
        cyc();
        chk_out("pp_a", 1'b1, 8'h10);
        chk("pp_a_ready", 32'(code_ready), 32'd1);
        code = 3'd0;
        cyc();
        chk_out("pp_b", 1'b1, 8'h01);
        code_valid = 1'b0;
        cyc();
        chk_out("pp_drain", 1'b0, 8'h00);

        // 6. Mid-stream reset with two buffered entries
        out_ready = 1'b0;
        code = 3'd3; code_valid = 1'b1;
        cyc();
        code = 3'd5;
        cyc();
        code_valid = 1'b0;
        chk("mr_full_ready", 32'(code_ready), 32'd0);
        chk_out("mr_full", 1'b1, 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mr_async", 1'b0, 8'h00);
        chk("mr_async_ready", 32'(code_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk_out("mr_empty", 1'b0, 8'h00);
`ifdef PRIO_DEC_CNT_EN
        chk("mr_dec_count", 32'(dec_count), 32'd0);
`endif

        // Five pops after reset
        code_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            code = 3'(7 - i);
            cyc();
            chk_out($sformatf("cnt%0d", i), 1'b1, one << (7 - i));
        end
        code_valid = 1'b0;
        cyc();
        chk_out("cnt_drain", 1'b0, 8'h00);
`ifdef PRIO_DEC_CNT_EN
        chk("dec_count5", 32'(dec_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("dec_count_rst", 32'(dec_count), 32'd0);
        cyc();
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
